// File: rtl/rat_int_ctrl.sv
// rat_int_ctrl: multi-channel interrupt controller for the RAT MCU.
// Synchronises raw IRQ lines, latches edge/level pending bits, applies a
// per-channel mask and presents one lowest-index-first request plus vector
// to the ControlUnit, gated by the global interrupt-enable (I) flag.
module rat_int_ctrl #(
  parameter int         N_CH         = 8,
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] MASK_PORT_ID = 8'h40,
  parameter logic [7:0] MODE_PORT_ID = 8'h41,
  parameter logic [7:0] CLR_PORT_ID  = 8'h42,
  localparam int        VEC_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_CH-1:0]   IRQ,
  input  logic              I_SET,
  input  logic              I_CLR,
  input  logic              IO_STRB,
  input  logic [7:0]        PORT_ID,
  input  logic [7:0]        OUT_PORT,
  input  logic              INT_ACK,
  output logic              INT,
  output logic [VEC_W-1:0]  INT_VEC,
  output logic              I_FLAG,
  output logic [N_CH-1:0]   PEND
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Lowest set index wins arbitration.
  function automatic logic [VEC_W-1:0] lowest_idx(input logic [N_CH-1:0] r);
    logic [VEC_W-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r[i]) idx = VEC_W'(i);
    end
    return idx;
  endfunction

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  sync_d [SYNC_STAGES];
  logic [N_CH-1:0]  edge_q, edge_d;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [N_CH-1:0]  mode_q, mode_d;
  logic             i_flag_q, i_flag_d;
  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             int_q, int_d;

  logic [N_CH-1:0]  sync_last;
  logic [N_CH-1:0]  wdata;
  logic             wr_mask, wr_mode, wr_clr;
  logic             ack_take;
  logic [N_CH-1:0]  set_bits;
  logic [N_CH-1:0]  clr_bits;
  logic [N_CH-1:0]  vec_onehot;
  logic [N_CH-1:0]  req;

  // Synchroniser chain shifting raw IRQ toward the edge detector.
  always_comb begin
    sync_d[0] = IRQ;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign edge_d    = sync_last;

  // IO port decode and pending-bit set/clear; a simultaneous set beats a clear.
  always_comb begin
    wdata      = OUT_PORT[N_CH-1:0];
    wr_mask    = IO_STRB && (PORT_ID == MASK_PORT_ID);
    wr_mode    = IO_STRB && (PORT_ID == MODE_PORT_ID);
    wr_clr     = IO_STRB && (PORT_ID == CLR_PORT_ID);
    ack_take   = INT_ACK && (state_q == ST_ASSERT);
    vec_onehot = N_CH'(1) << vec_q;

    // Level channels follow the synced line; edge channels catch 0->1 only.
    set_bits   = (mode_q & sync_last) | (~mode_q & sync_last & ~edge_q);

    clr_bits   = '0;
    if (wr_clr)   clr_bits = clr_bits | wdata;
    // Level channels are not auto-cleared on ack; their source owns the bit.
    if (ack_take) clr_bits = clr_bits | (vec_onehot & ~mode_q);

    pend_d     = (pend_q & ~clr_bits) | set_bits;
    mask_d     = wr_mask ? wdata : mask_q;
    mode_d     = wr_mode ? wdata : mode_q;
  end

  // Global enable: I_CLR dominates I_SET, and taking an interrupt disables.
  always_comb begin
    i_flag_d = i_flag_q;
    if (I_SET)    i_flag_d = 1'b1;
    if (I_CLR)    i_flag_d = 1'b0;
    if (ack_take) i_flag_d = 1'b0;
  end

  assign req = pend_q & mask_q;

  // Request FSM: arbitrate in IDLE, hold the vector in ASSERT, wait for RETIE.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    int_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_flag_q && (|req)) begin
          vec_d   = lowest_idx(req);
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (INT_ACK) begin
          state_d = ST_SERVICE;
        end else if (I_CLR || !i_flag_q) begin
          state_d = ST_IDLE;
        end else if (!req[vec_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (i_flag_q) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // INT is registered: it rises one cycle after entering ASSERT and drops
    // on the same edge that leaves ASSERT.
    int_d = (state_q == ST_ASSERT) && (state_d == ST_ASSERT);
  end

  // Synchroniser and edge-detect registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      edge_q <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      edge_q <= edge_d;
    end
  end

  // Pending, mask, mode and I-flag registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q   <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      i_flag_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      i_flag_q <= i_flag_d;
    end
  end

  // FSM state, latched vector and registered INT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      int_q   <= int_d;
    end
  end

  assign INT     = int_q;
  assign INT_VEC = vec_q;
  assign I_FLAG  = i_flag_q;
  assign PEND    = pend_q;

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Bench for rat_int_ctrl: directed scenarios, a randomized phase checked
// against a history-based model of pending bits and the I flag, and
// randomized priority trials checked against a lowest-index-first model.
module tb_rat_int_ctrl;

  localparam int N_CH = 8;

  logic       CLK;
  logic       RST;
  logic [7:0] IRQ;
  logic       I_SET, I_CLR, IO_STRB;
  logic [7:0] PORT_ID, OUT_PORT;
  logic       INT_ACK;
  logic       INT;
  logic [2:0] INT_VEC;
  logic       I_FLAG;
  logic [7:0] PEND;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  rat_int_ctrl #(.N_CH(N_CH), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .IRQ(IRQ), .I_SET(I_SET), .I_CLR(I_CLR),
    .IO_STRB(IO_STRB), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .INT_ACK(INT_ACK), .INT(INT), .INT_VEC(INT_VEC), .I_FLAG(I_FLAG),
    .PEND(PEND)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic io_wr(input logic [7:0] port, input logic [7:0] data);
    PORT_ID = port; OUT_PORT = data; IO_STRB = 1'b1;
    step();
    IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
  endtask

  task automatic set_i();
    I_SET = 1'b1; step(); I_SET = 1'b0;
  endtask

  task automatic ack();
    INT_ACK = 1'b1; step(); INT_ACK = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] p);
    IRQ = p; step(); IRQ = 8'h00;
  endtask

  task automatic wait_int(input string tag);
    for (int c = 0; c < 30 && INT !== 1'b1; c++) step();
    chk({tag, "_int"}, 32'(INT), 32'd1);
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference model state for the random phase.
  logic [7:0] m_pend, m_mode, p1, p2, p3, irq_r, wdat, set_v, clr_v;
  logic       m_i;
  int         sel;
  logic       iset_r, iclr_r;
  logic [7:0] pat, msk, rem;
  int         exp_vec;

  initial begin
    RST = 1'b1; IRQ = 8'h00; I_SET = 1'b0; I_CLR = 1'b0; IO_STRB = 1'b0;
    PORT_ID = 8'h00; OUT_PORT = 8'h00; INT_ACK = 1'b0;
    #1;
    chk("rst_int", 32'(INT), 32'd0);
    chk("rst_pend", 32'(PEND), 32'd0);
    chk("rst_iflag", 32'(I_FLAG), 32'd0);
    chk("rst_vec", 32'(INT_VEC), 32'd0);
    #22 RST = 1'b0;

    // Async reset in the middle of ASSERT.
    io_wr(8'h40, 8'hFF);
    set_i();
    pulse(8'h80);
    wait_int("t1");
    chk("t1_vec", 32'(INT_VEC), 32'd7);
    #3 RST = 1'b1;
    #1;
    chk("t1_arst_int", 32'(INT), 32'd0);
    chk("t1_arst_pend", 32'(PEND), 32'd0);
    chk("t1_arst_iflag", 32'(I_FLAG), 32'd0);
    #2 RST = 1'b0;

    // Mask cleared by reset: pending request must not interrupt until unmasked.
    set_i();
    pulse(8'h01);
    repeat (8) step();
    chk("t1_mask0_pend", 32'(PEND), 32'h01);
    chk("t1_mask0_int", 32'(INT), 32'd0);
    io_wr(8'h40, 8'h01);
    wait_int("t1m");
    chk("t1m_vec", 32'(INT_VEC), 32'd0);
    ack();
    chk("t1m_ack_pend", 32'(PEND), 32'h00);

    // Latency of a single-cycle pulse on IRQ[2].
    io_wr(8'h40, 8'h0F);
    set_i();
    pulse(8'h04);
    step(); step();
    chk("t2_pend_c3", 32'(PEND), 32'h04);
    chk("t2_int_c3", 32'(INT), 32'd0);
    step();
    chk("t2_int_c4", 32'(INT), 32'd0);
    step();
    chk("t2_int_c5", 32'(INT), 32'd1);
    chk("t2_vec", 32'(INT_VEC), 32'd2);
    ack();
    chk("t2_ack_pend", 32'(PEND), 32'h00);
    chk("t2_ack_iflag", 32'(I_FLAG), 32'd0);
    chk("t2_ack_int", 32'(INT), 32'd0);

    // Simultaneous IRQ[5] and IRQ[1].
    io_wr(8'h40, 8'hFF);
    set_i();
    pulse(8'h22);
    wait_int("t3a");
    chk("t3a_vec", 32'(INT_VEC), 32'd1);
    ack();
    chk("t3a_pend", 32'(PEND), 32'h20);
    set_i();
    wait_int("t3b");
    chk("t3b_vec", 32'(INT_VEC), 32'd5);
    ack();
    chk("t3b_pend", 32'(PEND), 32'h00);

    // Level mode on channel 3.
    io_wr(8'h41, 8'h08);
    set_i();
    IRQ = 8'h08;
    wait_int("t4a");
    chk("t4a_vec", 32'(INT_VEC), 32'd3);
    ack();
    chk("t4a_pend", 32'(PEND), 32'h08);
    chk("t4a_iflag", 32'(I_FLAG), 32'd0);
    set_i();
    wait_int("t4b");
    chk("t4b_vec", 32'(INT_VEC), 32'd3);
    ack();
    io_wr(8'h42, 8'h08);
    chk("t4_clr_hi0", 32'(PEND), 32'h08);
    step();
    chk("t4_clr_hi1", 32'(PEND), 32'h08);
    IRQ = 8'h00;
    repeat (4) step();
    io_wr(8'h42, 8'h08);
    chk("t4_clr_lo", 32'(PEND), 32'h00);
    io_wr(8'h41, 8'h00);

    // I_SET and I_CLR together: clear wins, no interrupt.
    pulse(8'h01);
    repeat (4) step();
    chk("t5_pend", 32'(PEND), 32'h01);
    I_SET = 1'b1; I_CLR = 1'b1;
    step();
    I_SET = 1'b0; I_CLR = 1'b0;
    chk("t5_iflag", 32'(I_FLAG), 32'd0);
    repeat (4) step();
    chk("t5_int", 32'(INT), 32'd0);
    set_i();
    wait_int("t5");
    chk("t5_vec", 32'(INT_VEC), 32'd0);
    ack();

    // Clearing the serviced request in ASSERT drops INT.
    set_i();
    pulse(8'h10);
    wait_int("t6");
    chk("t6_vec", 32'(INT_VEC), 32'd4);
    io_wr(8'h42, 8'h10);
    step();
    chk("t6_clr_int", 32'(INT), 32'd0);
    chk("t6_clr_pend", 32'(PEND), 32'h00);
    chk("t6_clr_iflag", 32'(I_FLAG), 32'd1);

    // Unmapped port 0x43 must not touch mask, mode or pending.
    io_wr(8'h43, 8'h00);
    pulse(8'h40);
    wait_int("t7");
    chk("t7_vec", 32'(INT_VEC), 32'd6);
    io_wr(8'h43, 8'hFF);
    chk("t7_p43_pend", 32'(PEND), 32'h40);
    chk("t7_p43_int", 32'(INT), 32'd1);

    // Higher-priority arrival does not disturb the held vector.
    pulse(8'h01);
    repeat (5) step();
    chk("t7_hold_vec", 32'(INT_VEC), 32'd6);
    chk("t7_hold_int", 32'(INT), 32'd1);
    chk("t7_hold_pend", 32'(PEND), 32'h41);

    // I_CLR in ASSERT: back to idle, pending kept.
    I_CLR = 1'b1; step(); I_CLR = 1'b0;
    chk("t8_iclr_int", 32'(INT), 32'd0);
    chk("t8_iclr_pend", 32'(PEND), 32'h41);
    chk("t8_iclr_iflag", 32'(I_FLAG), 32'd0);

    // Ack outside ASSERT is ignored.
    ack();
    chk("t8_stray_ack", 32'(PEND), 32'h41);
    set_i();
    wait_int("t8");
    chk("t8_vec", 32'(INT_VEC), 32'd0);
    ack();
    chk("t8_ack_pend", 32'(PEND), 32'h40);

    // Randomized phase: pending bits and I flag against a history model.
    IRQ = 8'h00;
    RST = 1'b1; #3 RST = 1'b0;
    m_pend = '0; m_mode = '0; m_i = 1'b0;
    p1 = '0; p2 = '0; p3 = '0; irq_r = '0;
    repeat (300) begin
      irq_r  = irq_r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      sel    = $urandom_range(0, 9);
      wdat   = 8'($urandom);
      iset_r = ($urandom_range(0, 5) == 0);
      iclr_r = ($urandom_range(0, 7) == 0);
      IRQ = irq_r; I_SET = iset_r; I_CLR = iclr_r;
      IO_STRB = (sel < 4); OUT_PORT = wdat;
      PORT_ID = (sel == 0) ? 8'h40 : (sel == 1) ? 8'h41 : (sel == 2) ? 8'h42 : 8'h43;
      // A channel is set by the value seen two edges ago (level) or by a
      // 0->1 between three and two edges ago (edge); a clear loses to a set.
      set_v  = (m_mode & p2) | (~m_mode & p2 & ~p3);
      clr_v  = (sel == 2) ? wdat : 8'h00;
      m_pend = (m_pend & ~clr_v) | set_v;
      if (sel == 1) m_mode = wdat;
      if (iset_r) m_i = 1'b1;
      if (iclr_r) m_i = 1'b0;
      p3 = p2; p2 = p1; p1 = irq_r;
      step();
      chk("rnd_pend", 32'(PEND), 32'(m_pend));
      chk("rnd_iflag", 32'(I_FLAG), 32'(m_i));
      chk("rnd_int_needs_i", 32'(INT & ~I_FLAG), 32'd0);
    end
    IRQ = 8'h00; I_SET = 1'b0; I_CLR = 1'b0; IO_STRB = 1'b0;
    PORT_ID = 8'h00; OUT_PORT = 8'h00;

    // Randomized priority trials: served in ascending index order.
    RST = 1'b1; #3 RST = 1'b0;
    repeat (3) step();
    repeat (8) begin
      pat = 8'($urandom);
      if (pat == 8'h00) pat = 8'h81;
      msk = 8'($urandom);
      if ((pat & msk) == 8'h00) msk = msk | pat;
      io_wr(8'h42, 8'hFF);
      io_wr(8'h40, msk);
      set_i();
      pulse(pat);
      rem = pat;
      while ((rem & msk) != 8'h00) begin
        wait_int("pri");
        exp_vec = lowest(rem & msk);
        chk("pri_vec", 32'(INT_VEC), 32'(exp_vec));
        ack();
        rem[exp_vec] = 1'b0;
        chk("pri_pend", 32'(PEND), 32'(rem));
        chk("pri_iflag", 32'(I_FLAG), 32'd0);
        set_i();
      end
      repeat (6) step();
      chk("pri_quiet_int", 32'(INT), 32'd0);
      chk("pri_left_pend", 32'(PEND), 32'(pat & ~msk));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rat_int_ctrl.md
Name: rat_int_ctrl

Overview:
- Parametrised multi-channel interrupt controller for the RAT MCU. It replaces the single raw INT line into the ControlUnit.
- Synchronises up to 8 external IRQ sources and latches them as edge- or level-triggered pending bits. Each channel can be masked through the IO port map.
- Presents one prioritised INT request plus a vector to the ControlUnit. It keeps the global interrupt-enable (I) flag, driven by I_SET and I_CLR.

Parameters:
- N_CH, 8, number of IRQ channels (1..8).
- SYNC_STAGES, 2, synchroniser flops per IRQ input (>=2).
- MASK_PORT_ID, 8'h40, IO port ID that writes the mask register.
- MODE_PORT_ID, 8'h41, IO port ID that writes the mode register (1=level, 0=edge).
- CLR_PORT_ID, 8'h42, IO port ID that clears pending bits (write-1-to-clear).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IRQ  in  N_CH  raw asynchronous interrupt sources.
- I_SET  in  1  from ControlUnit: set I flag (SEI/RETIE).
- I_CLR  in  1  from ControlUnit: clear I flag (CLI).
- IO_STRB  in  1  output strobe from ControlUnit.
- PORT_ID  in  8  IO address (IR[7:0]).
- OUT_PORT  in  8  IO write data (DX_OUT).
- INT_ACK  in  1  from ControlUnit: interrupt cycle entered.
- INT  out  1  interrupt request to ControlUnit.
- INT_VEC  out  max(1,$clog2(N_CH))  index of the channel being serviced.
- I_FLAG  out  1  current global enable.
- PEND  out  N_CH  pending register (for IN_PORT readback).

Behaviour:
- Reset (async, RST=1):
  - synchronisers, pending, mask, mode and I flag go to 0; all channels are masked and edge-mode.
  - state goes to IDLE; INT=0, INT_VEC=0, PEND=0, I_FLAG=0.
- Synchroniser: IRQ passes through SYNC_STAGES flops. An edge-detect flop follows the last stage.
- Edge-mode channel:
  - a rising edge of the synced IRQ sets pend[i]. The bit is visible SYNC_STAGES+1 cycles after the IRQ rises.
  - pend[i] stays set until ACK clears it or a CLR port write clears it.
- Level-mode channel: pend[i] is set every cycle the synced IRQ is 1. A clear while the level is still high is overridden the next cycle.
- Set/clear collision: a set and a clear of the same pend bit in the same cycle resolve to set.
- IO writes:
  - a write happens on the cycle IO_STRB=1 and PORT_ID matches a port parameter.
  - mask and mode registers take OUT_PORT[N_CH-1:0]; a CLR write clears pend where OUT_PORT bit=1.
  - OUT_PORT bits >= N_CH are ignored; non-matching PORT_IDs are ignored.
- I flag: I_SET sets it and I_CLR clears it. If both are asserted in one cycle, I_CLR wins. ACK also clears it (hardware auto-disable).
- Request vector: req = pend & mask. Priority is the lowest index.
- FSM, registered:
  - IDLE: if I_FLAG && |req, latch INT_VEC = lowest set index of req and go to ASSERT. INT rises in the cycle after the transition.
  - ASSERT:
    - INT=1 and INT_VEC is held stable, even if a higher-priority request appears.
    - On INT_ACK: clear pend[INT_VEC] (edge mode only), clear I flag, go to SERVICE. INT=0 the next cycle.
    - If the I flag is cleared (I_CLR) before ACK: go to IDLE with INT=0 and pending preserved.
    - If req[INT_VEC] drops (masked or cleared) before ACK: go to IDLE and re-arbitrate.
  - SERVICE: INT=0. Go to IDLE when I_FLAG=1 (RETIE). New pends accumulate meanwhile.
- INT_ACK outside ASSERT has no effect.
- N_CH=1: INT_VEC is 1 bit and always 0.
- Latency: from the IRQ edge, with the flag and mask enabled and the FSM in IDLE, to INT=1 is SYNC_STAGES+3 cycles.

Test Plan:
- RST=1 mid-ASSERT with INT=1 -> INT, PEND, I_FLAG and mask all 0 immediately, without waiting for a clock edge.
- mask=8'h0F, I_SET, IRQ[2] rising pulse of 1 cycle -> PEND=8'h04, INT=1 and INT_VEC=2 exactly 5 cycles after the edge; INT_ACK -> PEND=8'h00, I_FLAG=0, INT=0.
- IRQ[5] and IRQ[1] rise together, mask=8'hFF -> INT_VEC=1 first. After ACK and then I_SET, INT_VEC=5.
- Channel 3 in level mode, IRQ[3] held high, ACK then I_SET -> INT re-asserts with INT_VEC=3. A CLR write of 8'h08 while the IRQ is high leaves PEND[3]=1.
- I_SET and I_CLR together with pending masked-in request -> I_FLAG=0, INT stays 0. IRQ[0] pend with mask=0 -> no INT until mask write 8'h01.
- In ASSERT with INT_VEC=4, CLR write 8'h10 -> FSM returns to IDLE, INT=0. Writes to PORT_ID 8'h43 -> no register changes.
